// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latency defaults
// and the debug view of the sequencer state.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } mdu_op_e;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        mdu_state_e state;
        logic [3:0] cnt;
    } mdu_dbg_t;

    // Ops 0-3 occupy the unit for several cycles; everything else is single-edge.
    function automatic logic is_long_op(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Pure combinational multiply/divide datapath; {HI, LO} packed as result[63:32], result[31:0].
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic signed [63:0] w_sa;
    logic signed [63:0] w_sb;
    logic        [63:0] w_ua;
    logic        [63:0] w_ub;

    assign w_sa = {{32{a[31]}}, a};
    assign w_sb = {{32{b[31]}}, b};
    assign w_ua = {32'd0, a};
    assign w_ub = {32'd0, b};

    // Signed divide runs at 64 bits so 0x80000000 / -1 yields 2^31 and truncates cleanly.
    always_comb begin
        result = '0;
        case (op)
            OP_MULT:  result = w_sa * w_sb;
            OP_MULTU: result = w_ua * w_ub;
            OP_DIV: begin
                if (b != '0) begin
                    result = {32'(w_sa % w_sb), 32'(w_sa / w_sb)};
                end
            end
            OP_DIVU: begin
                if (b != '0) begin
                    result = {a % b, a / b};
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MDU sequencer: IDLE/BUSY FSM, latency counter, operand latches and HI/LO.
// start is a single-cycle strobe accepted only in IDLE; in BUSY it is dropped without effect.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output mdu_dbg_t    o_dbg
);

    localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYC);
    localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYC);

    mdu_state_e  r_state, w_state_nxt;
    logic [3:0]  r_cnt,   w_cnt_nxt;
    logic [1:0]  r_op,    w_op_nxt;
    logic [31:0] r_a,     w_a_nxt;
    logic [31:0] r_b,     w_b_nxt;
    logic [31:0] r_hi,    w_hi_nxt;
    logic [31:0] r_lo,    w_lo_nxt;
    logic [63:0] w_result;
    logic        w_div0;

    mdu_arith u_arith (
        .op     ({1'b0, r_op}),
        .a      (r_a),
        .b      (r_b),
        .result (w_result)
    );

    // Divide by zero still spends the full latency but must not touch HI/LO.
    assign w_div0 = r_op[1] & (r_b == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(op)) begin
                        w_op_nxt    = op[1:0];
                        w_a_nxt     = a;
                        w_b_nxt     = b;
                        w_cnt_nxt   = op[1] ? C_DIV_CNT : C_MULT_CNT;
                        w_state_nxt = ST_BUSY;
                    end else if (op == OP_MTHI) begin
                        w_hi_nxt = a;
                    end else if (op == OP_MTLO) begin
                        w_lo_nxt = a;
                    end
                end
            end
            ST_BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (!w_div0) begin
                        w_hi_nxt = w_result[63:32];
                        w_lo_nxt = w_result[31:0];
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy  = (r_state == ST_BUSY);
    assign stall = md_use_d & (busy | (start & is_long_op(op)));
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign o_dbg = '{state: r_state, cnt: r_cnt};

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed scenarios plus randomized ops against a
// plain-arithmetic HI/LO model.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd6;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        md_use_d = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    mdu_dbg_t    dbg;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_hl = '0;

    // ---------------- clock / DUT ----------------
    always #5 clk = ~clk;

    mdu_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo),
        .o_dbg    (dbg)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_model(input logic [2:0] m_op, input logic [31:0] m_a,
                                              input logic [31:0] m_b, input logic [63:0] cur);
        longint          sp;
        longint unsigned up;
        int              sa, sb, q, r;
        logic [31:0]     qb, rb;
        case (m_op)
            3'd0: begin
                sp = longint'($signed(m_a)) * longint'($signed(m_b));
                return sp;
            end
            3'd1: begin
                up = longint'(m_a) * longint'(m_b);
                return up;
            end
            3'd2: begin
                if (m_b == 32'd0) return cur;
                if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa = m_a;
                sb = m_b;
                q  = sa / sb;
                r  = sa % sb;
                qb = q;
                rb = r;
                return {rb, qb};
            end
            3'd3: begin
                if (m_b == 32'd0) return cur;
                return {m_a % m_b, m_a / m_b};
            end
            3'd4: return {m_a, cur[31:0]};
            3'd5: return {cur[63:32], m_a};
            default: return cur;
        endcase
    endfunction

    // ---------------- driver: one op from IDLE, checked through completion ----------------
    task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input logic t_use);
        logic [63:0] prev;
        logic [63:0] exp_v;
        int          n;
        prev     = model_hl;
        model_hl = ref_model(t_op, t_a, t_b, model_hl);
        exp_q.push_back(model_hl);
        start    = 1'b1;
        op       = t_op;
        a        = t_a;
        b        = t_b;
        md_use_d = t_use;
        #1;
        total_cnt++;
        if (stall !== (t_use && t_op <= 3'd3))
            $display("FAIL stall_start op=%0d got=%b want=%b", t_op, stall, (t_use && t_op <= 3'd3));
        else pass_cnt++;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (t_op <= 3'd3) begin
            n = (t_op >= 3'd2) ? DIV_CYC_DEF : MULT_CYC_DEF;
            for (int i = 0; i < n; i++) begin
                #1;
                total_cnt++;
                if (busy !== 1'b1) $display("FAIL busy_during op=%0d cyc=%0d got=%b want=1", t_op, i, busy);
                else pass_cnt++;
                total_cnt++;
                if (stall !== t_use) $display("FAIL stall_during op=%0d cyc=%0d got=%b want=%b", t_op, i, stall, t_use);
                else pass_cnt++;
                total_cnt++;
                if ({hi, lo} !== prev) $display("FAIL early_write op=%0d cyc=%0d got=%h want=%h", t_op, i, {hi, lo}, prev);
                else pass_cnt++;
                @(negedge clk);
            end
        end
        #1;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_done op=%0d got=%b want=0", t_op, busy);
        else pass_cnt++;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL stall_done op=%0d got=%b want=0", t_op, stall);
        else pass_cnt++;
        total_cnt++;
        if ({hi, lo} !== exp_v)
            $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", t_op, t_a, t_b, {hi, lo}, exp_v);
        else pass_cnt++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        md_use_d = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL reset_regs got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        else pass_cnt++;
        total_cnt++;
        if (dbg.state !== ST_IDLE || dbg.cnt !== 4'd0)
            $display("FAIL reset_fsm got state=%b cnt=%0d want IDLE/0", dbg.state, dbg.cnt);
        else pass_cnt++;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL reset_stall_idle got=%b want=0", stall);
        else pass_cnt++;
        // reset must win over a start arriving at the same edge
        start = 1'b1;
        op    = 3'd0;
        a     = 32'h1234;
        b     = 32'h5678;
        #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL reset_stall_start got=%b want=1", stall);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_dominates_start got busy=%b want=0", busy);
        else pass_cnt++;
        start    = 1'b0;
        md_use_d = 1'b0;
        reset    = 1'b0;
        model_hl = '0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        total_cnt++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA)
            $display("FAIL mult_directed got hi=%h lo=%h want FFFFFFFF/FFFFFFFA", hi, lo);
        else pass_cnt++;
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        total_cnt++;
        if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE)
            $display("FAIL multu_directed got hi=%h lo=%h want 00000001/FFFFFFFE", hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_div();
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        total_cnt++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
            $display("FAIL div_directed got hi=%h lo=%h want FFFFFFFF/FFFFFFFD", hi, lo);
        else pass_cnt++;
        run_op(3'd3, 32'd7, 32'd0, 1'b0);
        total_cnt++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
            $display("FAIL divu_by_zero got hi=%h lo=%h want FFFFFFFF/FFFFFFFD", hi, lo);
        else pass_cnt++;
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        total_cnt++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000)
            $display("FAIL div_overflow got hi=%h lo=%h want 00000000/80000000", hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        run_op(3'd0, 32'd12, 32'd13, 1'b1);
        run_op(3'd0, 32'd21, 32'd22, 1'b0);
        run_op(3'd4, 32'hCAFE_0001, 32'd0, 1'b1);
    endtask

    task automatic test_mthi_and_busy_ignore();
        logic [63:0] prev;
        run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        total_cnt++;
        if (hi !== 32'h1234_5678) $display("FAIL mthi_directed got=%h want=12345678", hi);
        else pass_cnt++;
        run_op(3'd5, 32'h0BAD_F00D, 32'd0, 1'b0);
        prev     = model_hl;
        model_hl = ref_model(3'd0, 32'h0000_1234, 32'h0000_0010, model_hl);
        start = 1'b1;
        op    = 3'd0;
        a     = 32'h0000_1234;
        b     = 32'h0000_0010;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        a     = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        total_cnt++;
        if (hi !== prev[63:32] || busy !== 1'b1)
            $display("FAIL mthi_in_busy got hi=%h busy=%b want %h/1", hi, busy, prev[63:32]);
        else pass_cnt++;
        total_cnt++;
        if (dbg.cnt !== 4'd3) $display("FAIL cnt_mid_busy got=%0d want=3", dbg.cnt);
        else pass_cnt++;
        op = 3'd2;
        b  = 32'd1;
        @(negedge clk);
        #1;
        total_cnt++;
        if (dbg.cnt !== 4'd2) $display("FAIL start_in_busy_reload got=%0d want=2", dbg.cnt);
        else pass_cnt++;
        start = 1'b0;
        @(negedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_last_cycle got=%b want=1", busy);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0 || {hi, lo} !== model_hl)
            $display("FAIL ignored_start_result got busy=%b hl=%h want 0/%h", busy, {hi, lo}, model_hl);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_div();
        run_op(3'd4, 32'hAAAA_5555, 32'd0, 1'b0);
        run_op(3'd5, 32'h0F0F_0F0F, 32'd0, 1'b0);
        start = 1'b1;
        op    = 3'd2;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd5;
        a     = 32'h55;
        @(negedge clk);
        #1;
        total_cnt++;
        if (dbg.state !== ST_IDLE || busy !== 1'b0)
            $display("FAIL reset_mid_div_state got state=%b busy=%b want IDLE/0", dbg.state, busy);
        else pass_cnt++;
        total_cnt++;
        if (hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL reset_mid_div_hilo got hi=%h lo=%h want 0/0", hi, lo);
        else pass_cnt++;
        reset    = 1'b0;
        start    = 1'b0;
        model_hl = '0;
        exp_q.delete();
        repeat (12) @(negedge clk);
        #1;
        total_cnt++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0)
            $display("FAIL no_late_write got hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        run_op(3'd5, 32'h0000_0042, 32'd0, 1'b1);
        run_op(3'd1, 32'h8765_4321, 32'h0001_0001, 1'b1);
        run_op(3'd3, 32'hFFFF_FFF0, 32'd9, 1'b0);
        run_op(3'd4, 32'h7777_0000, 32'd0, 1'b1);
        run_op(3'd2, 32'd50, 32'hFFFF_FFF9, 1'b1);
    endtask

    task automatic test_random();
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        for (int k = 0; k < 40; k++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)));
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mthi_and_busy_ignore();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL have the parameter MULT_CYC, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 The block SHALL have the parameter DIV_CYC, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 The block SHALL have the port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port start, input, 1 bit: E-stage MDU instruction valid this cycle.
REQ-006 The block SHALL have the port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-op.
REQ-007 The block SHALL have the port a, input, 32 bits: forwarded rs operand in E.
REQ-008 The block SHALL have the port b, input, 32 bits: forwarded rt operand in E.
REQ-009 The block SHALL have the port md_use_d, input, 1 bit: D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-010 The block SHALL have the port busy, output, 1 bit: an operation is in progress.
REQ-011 The block SHALL have the port stall, output, 1 bit: freeze PC and IF/ID and bubble ID/EX, ORed with the load-use stall.
REQ-012 The block SHALL have the port hi, output, 32 bits: HI register.
REQ-013 The block SHALL have the port lo, output, 32 bits: LO register.

Function
REQ-014 FSM states SHALL be IDLE and BUSY; a down-counter cnt SHALL be 4 bits wide.
REQ-015 In IDLE, start with op 0-3 SHALL latch the operands and the result-select, load cnt with MULT_CYC or DIV_CYC, and enter BUSY on the next edge.
REQ-016 In IDLE, start with op 4 or 5 SHALL write a to HI or LO at that edge and remain in IDLE, with busy 0.
REQ-017 In BUSY, cnt SHALL decrement each cycle; when cnt==1, hi and lo SHALL update at that edge and the state SHALL return to IDLE.
REQ-018 The result SHALL become visible to MFHI/MFLO exactly MULT_CYC or DIV_CYC cycles after the start edge.
REQ-019 busy SHALL be 1 exactly while in BUSY.
REQ-020 stall SHALL equal md_use_d AND (busy OR (start AND op<=3)), combinationally.
REQ-021 start asserted while in BUSY is a protocol error; it SHALL be ignored, with no state change.
REQ-022 MULT SHALL compute the signed 64-bit product a*b and MULTU the unsigned product, with HI = [63:32] and LO = [31:0].
REQ-023 DIV SHALL compute the signed quotient and remainder (truncate toward zero, remainder sign follows the dividend), with LO = quotient and HI = remainder; DIVU SHALL compute the unsigned equivalent.
REQ-024 Division by zero SHALL take DIV_CYC cycles and leave hi and lo unchanged.
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-026 Operands SHALL be latched at start, so later changes on a or b do not affect the result.

Reset
REQ-027 When reset is high at a clock edge, the block SHALL go to IDLE with cnt = 0, hi = 0, lo = 0, busy = 0; stall then follows REQ-020 combinationally.
REQ-028 Reset during BUSY SHALL abort the operation, discard its result, and dominate a simultaneous start.

Structure
REQ-029 The op encodings and the MULT_CYC/DIV_CYC defaults SHALL live in the shared package mdu_pkg, also imported by the decoder.
REQ-030 The pure combinational arithmetic SHALL be the sub-module mdu_arith (inputs: op, a, b; outputs: 64-bit result), instantiated once; mdu_seq holds only the FSM, counter, operand latches and HI/LO.

Verification
REQ-031 The bench SHALL check: MULT a=0xFFFFFFFE b=3 -> busy for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-032 The bench SHALL check: MULTU a=0xFFFFFFFF b=2 -> hi=1, lo=0xFFFFFFFE.
REQ-033 The bench SHALL check: DIV a=-7 b=2 -> after 10 cycles lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU a=7 b=0 -> hi and lo unchanged.
REQ-034 The bench SHALL check: MULT start with md_use_d=1 for MFLO -> stall=1 in the start cycle and all 5 busy cycles, then 0; stall=0 if md_use_d=0.
REQ-035 The bench SHALL check: MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle with busy=0; start during BUSY -> ignored.
REQ-036 The bench SHALL check: reset asserted at cycle 3 of a DIV -> next cycle state IDLE, hi=lo=0, busy=0, and no late result write.
